// File: rtl/snake_pkg.sv
// Shared direction encoding and arbiter state type for the snake game.
// The motion logic imports the same constants so both sides agree on what each direction code means.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } arb_state_t;

    // Opposite directions differ only in the low bit (up/down, left/right).
    function automatic dir_t dir_opposite(input dir_t d);
        return d ^ 2'b01;
    endfunction

    // The lowest set bit wins, so up > down > left > right.
    function automatic dir_t dir_pick(input logic [3:0] presses);
        dir_t r;
        r = DIR_UP;
        for (int i = 3; i >= 0; i--) begin
            if (presses[i]) r = dir_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/key_dir_arbiter_if.sv
// Key-to-snake command bus: the master drives the debounced keys and the tick.
// The slave (the arbiter) returns direction, status and pulses.
interface key_dir_arbiter_if #(
    parameter int FIFO_DEPTH = 2
);
    import snake_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [3:0]    key_v;
    logic          key_p;
    logic          tick;
    dir_t          dir;
    logic          dir_upd;
    logic          running;
    logic [CW-1:0] q_count;
    logic          drop;

    modport master (
        output key_v, key_p, tick,
        input  dir, dir_upd, running, q_count, drop
    );

    modport slave (
        input  key_v, key_p, tick,
        output dir, dir_upd, running, q_count, drop
    );

endinterface

// File: rtl/dir_fifo.sv
// Small synchronous turn buffer. Head and tail are readable combinationally, so the
// arbiter can compare against the newest entry and pop the oldest in the same cycle.
module dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  dir_t                         din,
    output dir_t                         head,
    output dir_t                         tail,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    dir_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push_ok;
    logic          pop_ok;

    // A push while full is only legal when a pop frees the slot in the same cycle.
    assign pop_ok  = pop && (count_reg != '0);
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) mem[wr_ptr_reg] <= din;
    end

    assign head  = mem[rd_ptr_reg];
    assign tail  = mem[wr_ptr_reg - AW'(1)];
    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/key_dir_arbiter.sv
// Turns debounced direction/pause key levels into buffered, validated snake turns.
// One buffered turn is released into dir per game tick.
module key_dir_arbiter
    import snake_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int INIT_DIR   = 3
) (
    input  logic               clk,
    input  logic               rst,
    key_dir_arbiter_if.slave   bus
);

    localparam int   CW       = $clog2(FIFO_DEPTH + 1);
    localparam dir_t INIT_VAL = dir_t'(INIT_DIR);

    arb_state_t    state_reg;
    arb_state_t    state_next;
    logic [3:0]    kv_q;
    logic          kp_q;
    dir_t          dir_reg;
    logic          dir_upd_reg;
    logic          running_reg;
    logic          drop_reg;

    logic [3:0]    new_v;
    logic          new_p;
    dir_t          cand;
    dir_t          ref_dir;
    logic          legal;
    logic          process;
    logic          pop;
    logic          push;
    logic          flush;
    logic          reject;

    dir_t          fifo_head;
    dir_t          fifo_tail;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            assign new_v[gi] = bus.key_v[gi] & ~kv_q[gi];
        end
    endgenerate

    assign new_p = bus.key_p & ~kp_q;
    assign cand  = dir_pick(new_v);

    // Compare against the last turn already queued, not the current heading,
    // so a queued "up" followed by "down" is still caught as a reversal.
    assign ref_dir = (fifo_count != '0) ? fifo_tail : dir_reg;
    assign legal   = (cand != ref_dir) && (cand != dir_opposite(ref_dir));

    // A pause press in RUN wins over any direction press or tick in the same cycle.
    always_comb begin
        state_next = state_reg;
        process    = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((|new_v) || new_p) begin
                    state_next = RUN;
                    process    = |new_v;
                end
            end
            RUN: begin
                if (new_p) begin
                    state_next = PAUSE;
                    flush      = 1'b1;
                end else begin
                    process = |new_v;
                    pop     = bus.tick && (fifo_count != '0);
                end
            end
            PAUSE: begin
                if (new_p) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    assign push   = process && legal && (!fifo_full || pop);
    assign reject = process && !push;

    dir_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (cand),
        .head  (fifo_head),
        .tail  (fifo_tail),
        .count (fifo_count),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            kv_q        <= '0;
            kp_q        <= 1'b0;
            dir_reg     <= INIT_VAL;
            dir_upd_reg <= 1'b0;
            running_reg <= 1'b0;
            drop_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            kv_q        <= bus.key_v;
            kp_q        <= bus.key_p;
            dir_upd_reg <= pop;
            running_reg <= (state_next == RUN);
            drop_reg    <= reject;
            if (pop) dir_reg <= fifo_head;
        end
    end

    assign bus.dir     = dir_reg;
    assign bus.dir_upd = dir_upd_reg;
    assign bus.running = running_reg;
    assign bus.q_count = fifo_count;
    assign bus.drop    = drop_reg;

endmodule

// File: tb/tb_key_dir_arbiter.sv
// Bench for key_dir_arbiter: directed scenarios with fixed expectations,
// followed by random stimulus checked against a queue-based reference model.
module tb_key_dir_arbiter;
    import snake_pkg::*;

    localparam int DEPTH = 2;
    localparam int INIT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_dir_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

    key_dir_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .INIT_DIR   (INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: mode 0 idle, 1 run, 2 pause; the queue holds pending turns.
    int m_mode;
    int m_dir;
    int m_q[$];
    int m_prev_v;
    int m_prev_p;
    int m_upd;
    int m_drop;
    int opp[4] = '{1, 0, 3, 2};

    task automatic model_step(input int kv, input int kp, input int tk, input int r);
        int newv, newp, c, refd;
        bit popping, accept;
        m_upd  = 0;
        m_drop = 0;
        if (r != 0) begin
            m_mode = 0; m_dir = INIT; m_q.delete(); m_prev_v = 0; m_prev_p = 0;
            return;
        end
        newv = kv & ~m_prev_v & 15;
        newp = kp & ~m_prev_p & 1;
        c = -1;
        for (int i = 0; i < 4; i++) if (c < 0 && ((newv >> i) & 1) == 1) c = i;
        refd = (m_q.size() > 0) ? m_q[$] : m_dir;
        popping = 0;
        accept  = 0;
        if (m_mode == 0) begin
            if (newv != 0 || newp != 0) m_mode = 1;
        end else if (m_mode == 1) begin
            if (newp != 0) begin
                m_mode = 2; m_q.delete(); c = -1;
            end else begin
                popping = (tk != 0) && (m_q.size() > 0);
            end
        end else begin
            if (newp != 0) m_mode = 1;
            c = -1;
        end
        if (c >= 0) begin
            if (c == refd || c == opp[refd]) m_drop = 1;
            else if (m_q.size() == DEPTH && !popping) m_drop = 1;
            else accept = 1;
        end
        if (popping) begin
            m_dir = m_q.pop_front();
            m_upd = 1;
        end
        if (accept) m_q.push_back(c);
        m_prev_v = kv;
        m_prev_p = kp;
    endtask

    task automatic cyc(input logic [3:0] kv, input logic kp, input logic tk, input logic r);
        @(negedge clk);
        bus.key_v = kv;
        bus.key_p = kp;
        bus.tick  = tk;
        rst       = r;
        @(posedge clk);
        model_step(int'(kv), int'(kp), int'(tk), int'(r));
        #1;
    endtask

    task automatic test_reset();
        cyc(4'b0000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (bus.dir !== 2'(INIT)) begin n_fail++; $display("FAIL reset.dir: got %0d want %0d", bus.dir, INIT); end
        n_cmp++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL reset.running: got %0b want 0", bus.running); end
        n_cmp++; if (bus.q_count !== 0) begin n_fail++; $display("FAIL reset.q_count: got %0d want 0", bus.q_count); end
        n_cmp++; if (bus.dir_upd !== 1'b0 || bus.drop !== 1'b0) begin n_fail++; $display("FAIL reset.pulses: got upd=%0b drop=%0b want 0 0", bus.dir_upd, bus.drop); end
    endtask

    task automatic test_first_press();
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.running !== 1'b1) begin n_fail++; $display("FAIL first_press.running: got %0b want 1", bus.running); end
        n_cmp++; if (bus.q_count !== 1) begin n_fail++; $display("FAIL first_press.q_count: got %0d want 1", bus.q_count); end
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.q_count !== 1) begin n_fail++; $display("FAIL first_press.held_q: got %0d want 1", bus.q_count); end
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.dir !== 2'd0 || bus.dir_upd !== 1'b1) begin n_fail++; $display("FAIL first_press.tick: got dir=%0d upd=%0b want 0 1", bus.dir, bus.dir_upd); end
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.dir_upd !== 1'b0) begin n_fail++; $display("FAIL first_press.upd_once: got %0b want 0", bus.dir_upd); end
    endtask

    task automatic test_reversal_dup();
        cyc(4'b1000, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.dir !== 2'd3) begin n_fail++; $display("FAIL rev_dup.setup_dir: got %0d want 3", bus.dir); end
        cyc(4'b0100, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.drop !== 1'b1 || bus.q_count !== 0) begin n_fail++; $display("FAIL rev_dup.reversal: got drop=%0b q=%0d want 1 0", bus.drop, bus.q_count); end
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.drop !== 1'b0) begin n_fail++; $display("FAIL rev_dup.drop_pulse: got %0b want 0", bus.drop); end
        cyc(4'b1000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.drop !== 1'b1 || bus.q_count !== 0) begin n_fail++; $display("FAIL rev_dup.duplicate: got drop=%0b q=%0d want 1 0", bus.drop, bus.q_count); end
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        cyc(4'b1101, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.q_count !== 1 || bus.drop !== 1'b0) begin n_fail++; $display("FAIL priority.enq: got q=%0d drop=%0b want 1 0", bus.q_count, bus.drop); end
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.dir !== 2'd0) begin n_fail++; $display("FAIL priority.winner: got %0d want 0", bus.dir); end
        cyc(4'b1000, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_buffer_full();
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(4'b0100, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.q_count !== 2) begin n_fail++; $display("FAIL buffer.q_full: got %0d want 2", bus.q_count); end
        cyc(4'b0010, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.drop !== 1'b1 || bus.q_count !== 2) begin n_fail++; $display("FAIL buffer.overflow: got drop=%0b q=%0d want 1 2", bus.drop, bus.q_count); end
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.dir !== 2'd0 || bus.q_count !== 1) begin n_fail++; $display("FAIL buffer.pop1: got dir=%0d q=%0d want 0 1", bus.dir, bus.q_count); end
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.dir !== 2'd2 || bus.q_count !== 0) begin n_fail++; $display("FAIL buffer.pop2: got dir=%0d q=%0d want 2 0", bus.dir, bus.q_count); end
    endtask

    task automatic test_push_pop_full();
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(4'b0010, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.dir !== 2'd0 || bus.dir_upd !== 1'b1) begin n_fail++; $display("FAIL push_pop.head: got dir=%0d upd=%0b want 0 1", bus.dir, bus.dir_upd); end
        n_cmp++; if (bus.q_count !== 2 || bus.drop !== 1'b0) begin n_fail++; $display("FAIL push_pop.accept: got q=%0d drop=%0b want 2 0", bus.q_count, bus.drop); end
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.dir !== 2'd3) begin n_fail++; $display("FAIL back_to_back.pop1: got %0d want 3", bus.dir); end
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.dir !== 2'd1 || bus.q_count !== 0) begin n_fail++; $display("FAIL back_to_back.pop2: got dir=%0d q=%0d want 1 0", bus.dir, bus.q_count); end
    endtask

    task automatic test_pause();
        cyc(4'b0100, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.running !== 1'b0 || bus.q_count !== 0) begin n_fail++; $display("FAIL pause.enter: got run=%0b q=%0d want 0 0", bus.running, bus.q_count); end
        cyc(4'b0000, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus.dir !== 2'd1 || bus.dir_upd !== 1'b0) begin n_fail++; $display("FAIL pause.tick_ignored: got dir=%0d upd=%0b want 1 0", bus.dir, bus.dir_upd); end
        cyc(4'b1000, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.drop !== 1'b0 || bus.q_count !== 0) begin n_fail++; $display("FAIL pause.key_ignored: got drop=%0b q=%0d want 0 0", bus.drop, bus.q_count); end
        cyc(4'b1000, 1'b0, 1'b0, 1'b0);
        cyc(4'b1000, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.running !== 1'b1 || bus.q_count !== 0) begin n_fail++; $display("FAIL pause.resume: got run=%0b q=%0d want 1 0", bus.running, bus.q_count); end
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        cyc(4'b0100, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (bus.dir !== 2'(INIT) || bus.running !== 1'b0 || bus.q_count !== 0) begin n_fail++; $display("FAIL reset_mid: got dir=%0d run=%0b q=%0d want %0d 0 0", bus.dir, bus.running, bus.q_count, INIT); end
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.running !== 1'b0 || bus.dir_upd !== 1'b0) begin n_fail++; $display("FAIL reset_mid.idle_tick: got run=%0b upd=%0b want 0 0", bus.running, bus.dir_upd); end
    endtask

    task automatic test_random();
        logic [3:0] kv;
        logic kp, tk, r;
        kv = 4'b0000; kp = 1'b0;
        cyc(4'b0000, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(2) == 0) kv = 4'($urandom_range(15));
            if ($urandom_range(15) == 0) kp = ~kp;
            tk = ($urandom_range(2) == 0);
            r  = ($urandom_range(249) == 0);
            cyc(kv, kp, tk, r);
            n_cmp++;
            if (bus.dir !== 2'(m_dir) || bus.dir_upd !== 1'(m_upd) || bus.running !== 1'(m_mode == 1) ||
                bus.q_count !== m_q.size() || bus.drop !== 1'(m_drop)) begin
                n_fail++;
                $display("FAIL random[%0d]: got dir=%0d upd=%0b run=%0b q=%0d drop=%0b want %0d %0d %0d %0d %0d",
                         n, bus.dir, bus.dir_upd, bus.running, bus.q_count, bus.drop,
                         m_dir, m_upd, (m_mode == 1), m_q.size(), m_drop);
            end
        end
    endtask

    initial begin
        bus.key_v = 4'b0000;
        bus.key_p = 1'b0;
        bus.tick  = 1'b0;
        m_mode = 0; m_dir = INIT; m_prev_v = 0; m_prev_p = 0; m_upd = 0; m_drop = 0;
        test_reset();
        test_first_press();
        test_reversal_dup();
        test_priority();
        test_buffer_full();
        test_push_pop_full();
        test_pause();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
